// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Contents: RV32I funct3 access codes, responder FSM state type, latency range.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal access latency range; the counter is sized to hold LATENCY_MAX.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - RV32I byte/halfword lane steering, extension and access checks
// Ports:
//   we_i      1 = store, 0 = load
//   funct3_i  RV32I access type
//   addr_i    low two byte-address bits
//   rdata_i   stored word at the addressed word location
//   wdata_i   right-aligned store data
//   ldata_o   extended load data (0 for stores and errors)
//   be_o      byte write-enable (0 for loads and errors)
//   sdata_o   store data replicated onto its byte lanes
//   err_o     misaligned or illegal access
module lsu_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [3:0]  be_o,
    output logic [31:0] sdata_o,
    output logic        err_o
);

    // Addressed byte/halfword moved down to bit 0 (little-endian lanes).
    logic [31:0] shifted;
    assign shifted = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        ldata_o = 32'd0;
        be_o    = 4'b0000;
        sdata_o = 32'd0;
        err_o   = 1'b0;
        unique case (funct3_i)
            F3_B: begin
                if (we_i) begin
                    be_o    = 4'b0001 << addr_i;
                    sdata_o = {4{wdata_i[7:0]}};
                end else begin
                    ldata_o = {{24{shifted[7]}}, shifted[7:0]};
                end
            end
            F3_H: begin
                if (addr_i[0]) begin
                    err_o = 1'b1;
                end else if (we_i) begin
                    be_o    = 4'b0011 << addr_i;
                    sdata_o = {2{wdata_i[15:0]}};
                end else begin
                    ldata_o = {{16{shifted[15]}}, shifted[15:0]};
                end
            end
            F3_W: begin
                if (addr_i != 2'b00) begin
                    err_o = 1'b1;
                end else if (we_i) begin
                    be_o    = 4'b1111;
                    sdata_o = wdata_i;
                end else begin
                    ldata_o = rdata_i;
                end
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                if (we_i) begin
                    err_o = 1'b1;
                end else begin
                    ldata_o = {24'd0, shifted[7:0]};
                end
            end
            F3_HU: begin
                if (we_i || addr_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    ldata_o = {16'd0, shifted[15:0]};
                end
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable data memory servicing RV32I loads/stores
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_funct3    store/load select and RV32I access type
//   req_addr, req_wdata   byte address and right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    extended load data / access error, qualified by rsp_valid
//   busy                  request outstanding (pipeline stall)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int WORDS      = 1 << (ADDR_WIDTH - 2);
    localparam int CNT_INIT_I = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    // Word-organised storage; byte writes go through per-lane enables.
    logic [31:0] mem_q [WORDS];

    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic        acc_err;
    logic        mem_we;

    // Address bits above the decoded range are ignored so the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_word = mem_q[addr_q[ADDR_WIDTH-1:2]];

    lsu_align u_lsu_align (
        .we_i     (we_q),
        .funct3_i (f3_q),
        .addr_i   (addr_q[1:0]),
        .rdata_i  (rd_word),
        .wdata_i  (wdata_q),
        .ldata_o  (ld_data),
        .be_o     (be),
        .sdata_o  (st_data),
        .err_o    (acc_err)
    );

    // The store commits on the edge leaving RESP. rst is included so an edge
    // coinciding with reset assertion can never complete a discarded store.
    assign mem_we = (state_q == RESP) && we_q && !acc_err && rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && acc_err;
    assign rsp_rdata = rsp_valid ? ld_data : '0;

endmodule
